// File: rtl/mcaster_buf.sv
// Column multicaster: filters three tagged bus channels by column ID or broadcast,
// buffers matching beats in per-channel FWFT FIFOs toward the PE, and counts drops.
module mcaster_buf #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned NUM_COL    = 4,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned BCAST_EN   = 1,
  localparam int unsigned ID_W      = (NUM_COL > 1) ? $clog2(NUM_COL) : 1,
  localparam int unsigned TAG_W     = ID_W + 1,
  localparam int unsigned PSUM_W    = 2 * DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  id_we,
  input  logic [ID_W-1:0]       id_wdata,
  output logic [ID_W-1:0]       id,
  input  logic [TAG_W-1:0]      ifmap_tag_i,
  input  logic [DATA_WIDTH-1:0] ifmap_data_i,
  input  logic                  ifmap_valid_i,
  output logic                  ifmap_ready_o,
  output logic [DATA_WIDTH-1:0] ifmap_data_o,
  output logic                  ifmap_valid_o,
  input  logic                  ifmap_ready_i,
  input  logic [TAG_W-1:0]      fltr_tag_i,
  input  logic [DATA_WIDTH-1:0] fltr_data_i,
  input  logic                  fltr_valid_i,
  output logic                  fltr_ready_o,
  output logic [DATA_WIDTH-1:0] fltr_data_o,
  output logic                  fltr_valid_o,
  input  logic                  fltr_ready_i,
  input  logic [TAG_W-1:0]      psum_tag_i,
  input  logic [PSUM_W-1:0]     psum_data_i,
  input  logic                  psum_valid_i,
  output logic                  psum_ready_o,
  output logic [PSUM_W-1:0]     psum_data_o,
  output logic                  psum_valid_o,
  input  logic                  psum_ready_i,
  output logic                  pe_en,
  output logic [7:0]            drop_cnt
);

  localparam int unsigned NCH   = 3;
  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [ID_W-1:0]  id_q;
  logic [7:0]       drop_q;
  logic             pe_en_q;
  logic [TAG_W-1:0] ch_tag     [NCH];
  logic             ch_valid_i [NCH];
  logic             ch_ready_i [NCH];
  logic             ch_drop    [NCH];
  logic             ch_vld_nxt [NCH];
  logic [1:0]       drop_add;
  logic [8:0]       drop_sum;

  assign ch_tag[0]     = ifmap_tag_i;
  assign ch_tag[1]     = fltr_tag_i;
  assign ch_tag[2]     = psum_tag_i;
  assign ch_valid_i[0] = ifmap_valid_i;
  assign ch_valid_i[1] = fltr_valid_i;
  assign ch_valid_i[2] = psum_valid_i;
  assign ch_ready_i[0] = ifmap_ready_i;
  assign ch_ready_i[1] = fltr_ready_i;
  assign ch_ready_i[2] = psum_ready_i;

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    localparam int unsigned W = (c == 2) ? PSUM_W : DATA_WIDTH;

    logic [W-1:0]     wdata;
    logic [W-1:0]     head_q;
    logic [W-1:0]     head_nxt;
    logic [W-1:0]     mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W-1:0] rd_ptr_inc;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_nxt;
    logic             ready_q;
    logic             valid_q;
    logic             match;
    logic             xfer;
    logic             push;
    logic             pop;

    if (c == 0) begin : g_ifmap
      assign wdata = ifmap_data_i;
    end else if (c == 1) begin : g_fltr
      assign wdata = fltr_data_i;
    end else begin : g_psum
      assign wdata = psum_data_i;
    end

    // Foreign tags are still consumed whenever the FIFO has room, so the bus never stalls on them.
    assign match = ((ch_tag[c][ID_W-1:0] == id_q) && !ch_tag[c][ID_W]) ||
                   ((BCAST_EN != 0) && ch_tag[c][ID_W]);
    assign xfer        = ch_valid_i[c] && ready_q;
    assign push        = xfer && match;
    assign ch_drop[c]  = xfer && !match;
    assign pop         = valid_q && ch_ready_i[c];
    assign rd_ptr_inc  = rd_ptr_q + PTR_W'(1);
    assign ch_vld_nxt[c] = (count_nxt != '0);

    // Head register holds the next output word so data_o comes straight from a flop.
    always_comb begin
      count_nxt = count_q;
      head_nxt  = head_q;
      if (push && !pop) begin
        count_nxt = count_q + CNT_W'(1);
      end else if (pop && !push) begin
        count_nxt = count_q - CNT_W'(1);
      end
      if (push && ((count_q == '0) || ((count_q == CNT_W'(1)) && pop))) begin
        head_nxt = wdata;
      end else if (pop) begin
        head_nxt = mem[rd_ptr_inc];
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        count_q  <= '0;
        head_q   <= '0;
        valid_q  <= 1'b0;
        ready_q  <= 1'b0;
      end else begin
        if (push) begin
          mem[wr_ptr_q] <= wdata;
          wr_ptr_q      <= wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
          rd_ptr_q <= rd_ptr_inc;
        end
        count_q <= count_nxt;
        head_q  <= head_nxt;
        valid_q <= (count_nxt != '0);
        ready_q <= (count_nxt != CNT_W'(FIFO_DEPTH));
      end
    end
  end

  assign drop_add = 2'(ch_drop[0]) + 2'(ch_drop[1]) + 2'(ch_drop[2]);
  assign drop_sum = 9'(drop_q) + 9'(drop_add);

  always_ff @(posedge clk) begin
    if (rst) begin
      id_q    <= '0;
      drop_q  <= '0;
      pe_en_q <= 1'b0;
    end else begin
      if (id_we) begin
        id_q <= id_wdata;
      end
      drop_q  <= drop_sum[8] ? 8'hFF : drop_sum[7:0];
      pe_en_q <= ch_vld_nxt[0] || ch_vld_nxt[1] || ch_vld_nxt[2];
    end
  end

  assign id            = id_q;
  assign drop_cnt      = drop_q;
  assign pe_en         = pe_en_q;
  assign ifmap_ready_o = g_ch[0].ready_q;
  assign ifmap_valid_o = g_ch[0].valid_q;
  assign ifmap_data_o  = g_ch[0].head_q;
  assign fltr_ready_o  = g_ch[1].ready_q;
  assign fltr_valid_o  = g_ch[1].valid_q;
  assign fltr_data_o   = g_ch[1].head_q;
  assign psum_ready_o  = g_ch[2].ready_q;
  assign psum_valid_o  = g_ch[2].valid_q;
  assign psum_data_o   = g_ch[2].head_q;

endmodule
